// File: rtl/axa_pkg.sv
// Shared definitions for the AxA tile feeder: word width, FSM encoding and
// the order in which the eight words of an A/B tile pair are fetched.
package axa_pkg;

    localparam int WORD_W     = 32;
    localparam int TILE_WORDS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Word index w: bit 2 selects the B tile, bit 1 the row, bit 0 the column.
    localparam logic [2:0] W_A11 = 3'd0;
    localparam logic [2:0] W_A12 = 3'd1;
    localparam logic [2:0] W_A21 = 3'd2;
    localparam logic [2:0] W_A22 = 3'd3;
    localparam logic [2:0] W_B11 = 3'd4;
    localparam logic [2:0] W_B12 = 3'd5;
    localparam logic [2:0] W_B21 = 3'd6;
    localparam logic [2:0] W_B22 = 3'd7;

    function automatic logic word_is_b(input logic [2:0] w);
        return w[2];
    endfunction

    function automatic logic word_row(input logic [2:0] w);
        return w[1];
    endfunction

    function automatic logic word_col(input logic [2:0] w);
        return w[0];
    endfunction

endpackage

// File: rtl/axa_tile_feeder_if.sv
// Bundle of start/base inputs, RAM read port and the Stable/Ack tile port
// between the tile feeder (master) and its environment (slave).
interface axa_tile_feeder_if
    import axa_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 1
);
    logic              input_Start;
    logic [ADDR_W-1:0] input_A_Base;
    logic [ADDR_W-1:0] input_B_Base;
    logic              output_Mem_Rd;
    logic [ADDR_W-1:0] output_Mem_Addr;
    logic [WORD_W-1:0] input_Mem_Data;
    logic [WORD_W-1:0] output_A11, output_A12, output_A21, output_A22;
    logic [WORD_W-1:0] output_B11, output_B12, output_B21, output_B22;
    logic              output_Stable;
    logic              input_AB_Ack;
    logic [IDX_W-1:0]  output_Tile_I, output_Tile_J, output_Tile_K;
    logic              output_Last_K;
    logic              output_Busy;
    logic              output_Done;

    // Four-phase handshake: Stable rises with tile/index outputs frozen; the sink
    // raises Ack; Stable falls; the sink drops Ack; only then is the next tile fetched.
    modport master (
        input  input_Start, input_A_Base, input_B_Base, input_Mem_Data, input_AB_Ack,
        output output_Mem_Rd, output_Mem_Addr,
        output output_A11, output_A12, output_A21, output_A22,
        output output_B11, output_B12, output_B21, output_B22,
        output output_Stable, output_Tile_I, output_Tile_J, output_Tile_K,
        output output_Last_K, output_Busy, output_Done
    );

    modport slave (
        output input_Start, input_A_Base, input_B_Base, input_Mem_Data, input_AB_Ack,
        input  output_Mem_Rd, output_Mem_Addr,
        input  output_A11, output_A12, output_A21, output_A22,
        input  output_B11, output_B12, output_B21, output_B22,
        input  output_Stable, output_Tile_I, output_Tile_J, output_Tile_K,
        input  output_Last_K, output_Busy, output_Done
    );

endinterface

// File: rtl/tile_addr_gen.sv
// Block/word counters for the tile walk (k innermost, then j, then i) and the
// RAM word address of the current fetch word, modulo 2^ADDR_W.
module tile_addr_gen
    import axa_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step_word,
    input  logic              next_tile,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        word,
    output logic [IDX_W-1:0]  i,
    output logic [IDX_W-1:0]  j,
    output logic [IDX_W-1:0]  k,
    output logic              word_done,
    output logic              last_k,
    output logic              last_tile
);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(N / 2 - 1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(N);

    logic [3:0]        w_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q;
    logic [ADDR_W-1:0] base, row, col;
    logic [IDX_W-1:0]  row_blk, col_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q      <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else if (clear) begin
            w_q      <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            a_base_q <= a_base;
            b_base_q <= b_base;
        end else if (next_tile) begin
            w_q <= '0;
            if (k != IDX_MAX) begin
                k <= k + 1'b1;
            end else begin
                k <= '0;
                if (j != IDX_MAX) begin
                    j <= j + 1'b1;
                end else begin
                    j <= '0;
                    i <= (i == IDX_MAX) ? '0 : i + 1'b1;
                end
            end
        end else if (step_word) begin
            w_q <= w_q + 4'd1;
        end
    end

    // A tile (i,k) walks A rows 2i+r, columns 2k+c; B tile (k,j) walks rows 2k+r, columns 2j+c.
    always_comb begin
        base    = a_base_q;
        row_blk = i;
        col_blk = k;
        if (word_is_b(w_q[2:0])) begin
            base    = b_base_q;
            row_blk = k;
            col_blk = j;
        end
        row  = (ADDR_W'(row_blk) << 1) | ADDR_W'(word_row(w_q[2:0]));
        col  = (ADDR_W'(col_blk) << 1) | ADDR_W'(word_col(w_q[2:0]));
        addr = base + row * STRIDE + col;
    end

    assign word      = w_q[2:0];
    assign word_done = (w_q == 4'(TILE_WORDS));
    assign last_k    = (k == IDX_MAX);
    assign last_tile = last_k && (i == IDX_MAX) && (j == IDX_MAX);

endmodule

// File: rtl/axa_tile_feeder.sv
// Walks the block triples of A*B, fetches each A/B 2x2 tile pair from word RAM
// and presents it to the AxA multiplier over the Stable/Ack handshake.
module axa_tile_feeder
    import axa_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 10,
    parameter int IDX_W  = (N / 2 > 1) ? $clog2(N / 2) : 1
) (
    input  logic              input_Clk,
    input  logic              input_Reset,
    axa_tile_feeder_if.master bus,
    output state_t            debug_state
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] gen_addr, addr_hold_q;
    logic [2:0]        word;
    logic [IDX_W-1:0]  cur_i, cur_j, cur_k;
    logic              word_done, cur_last_k, last_tile;
    logic              start_ok, rd, release_go;
    logic              vld_q;
    logic [2:0]        cap_idx_q;
    logic [WORD_W-1:0] tile_q [TILE_WORDS];
    logic [IDX_W-1:0]  tile_i_q, tile_j_q, tile_k_q;
    logic              last_k_q;

    assign start_ok   = (state_q == ST_IDLE) && bus.input_Start;
    assign rd         = (state_q == ST_FETCH) && !word_done;
    assign release_go = (state_q == ST_RELEASE) && !bus.input_AB_Ack;

    tile_addr_gen #(.N(N), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_addr_gen (
        .clk       (input_Clk),
        .rst_n     (input_Reset),
        .clear     (start_ok),
        .step_word (rd),
        .next_tile (release_go),
        .a_base    (bus.input_A_Base),
        .b_base    (bus.input_B_Base),
        .addr      (gen_addr),
        .word      (word),
        .i         (cur_i),
        .j         (cur_j),
        .k         (cur_k),
        .word_done (word_done),
        .last_k    (cur_last_k),
        .last_tile (last_tile)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.input_Start) state_d = ST_FETCH;
            ST_FETCH:   if (word_done) state_d = ST_PRESENT;
            ST_PRESENT: if (bus.input_AB_Ack) state_d = ST_RELEASE;
            ST_RELEASE: if (!bus.input_AB_Ack) state_d = last_tile ? ST_DONE : ST_FETCH;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read data lands one cycle after the strobe; vld_q/cap_idx_q track which word it is.
    always_ff @(posedge input_Clk or negedge input_Reset) begin
        if (!input_Reset) begin
            state_q     <= ST_IDLE;
            addr_hold_q <= '0;
            vld_q       <= 1'b0;
            cap_idx_q   <= '0;
            tile_i_q    <= '0;
            tile_j_q    <= '0;
            tile_k_q    <= '0;
            last_k_q    <= 1'b0;
            for (int n = 0; n < TILE_WORDS; n++) tile_q[n] <= '0;
        end else begin
            state_q   <= state_d;
            vld_q     <= rd;
            cap_idx_q <= word;
            if (rd) addr_hold_q <= gen_addr;
            if (vld_q) tile_q[cap_idx_q] <= bus.input_Mem_Data;
            if ((state_q == ST_FETCH) && word_done) begin
                tile_i_q <= cur_i;
                tile_j_q <= cur_j;
                tile_k_q <= cur_k;
                last_k_q <= cur_last_k;
            end
        end
    end

    assign bus.output_Mem_Rd   = rd;
    assign bus.output_Mem_Addr = rd ? gen_addr : addr_hold_q;
    assign bus.output_A11      = tile_q[W_A11];
    assign bus.output_A12      = tile_q[W_A12];
    assign bus.output_A21      = tile_q[W_A21];
    assign bus.output_A22      = tile_q[W_A22];
    assign bus.output_B11      = tile_q[W_B11];
    assign bus.output_B12      = tile_q[W_B12];
    assign bus.output_B21      = tile_q[W_B21];
    assign bus.output_B22      = tile_q[W_B22];
    assign bus.output_Stable   = (state_q == ST_PRESENT);
    assign bus.output_Tile_I   = tile_i_q;
    assign bus.output_Tile_J   = tile_j_q;
    assign bus.output_Tile_K   = tile_k_q;
    assign bus.output_Last_K   = last_k_q;
    assign bus.output_Busy     = (state_q != ST_IDLE);
    assign bus.output_Done     = (state_q == ST_DONE);
    assign debug_state         = state_q;

endmodule

// File: tb/tb_axa_tile_feeder.sv
// Bench for axa_tile_feeder: an N=2 and an N=4 instance share one word RAM;
// every tile is compared with a loop-nest reference model of the block walk.
module tb_axa_tile_feeder;
    import axa_pkg::*;

    localparam int AW = 10;

    typedef struct packed {
        logic [1:0]           i, j, k;
        logic                 lk;
        logic [7:0][31:0]     d;
        logic [7:0][AW-1:0]   a;
    } tile_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          start, ack, sel2;
    logic [AW-1:0] a_base, b_base;
    state_t        st2, st4;

    axa_tile_feeder_if #(.ADDR_W(AW), .IDX_W(1)) b2 ();
    axa_tile_feeder_if #(.ADDR_W(AW), .IDX_W(1)) b4 ();

    axa_tile_feeder #(.N(2), .ADDR_W(AW)) dut2 (
        .input_Clk(clk), .input_Reset(rst_n), .bus(b2), .debug_state(st2));
    axa_tile_feeder #(.N(4), .ADDR_W(AW)) dut4 (
        .input_Clk(clk), .input_Reset(rst_n), .bus(b4), .debug_state(st4));

    assign b2.input_Start  = start & sel2;
    assign b4.input_Start  = start & ~sel2;
    assign b2.input_AB_Ack = ack & sel2;
    assign b4.input_AB_Ack = ack & ~sel2;
    assign b2.input_A_Base = a_base;
    assign b4.input_A_Base = a_base;
    assign b2.input_B_Base = b_base;
    assign b4.input_B_Base = b_base;

    // Word RAM: data valid the cycle after the strobe, junk otherwise.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        b2.input_Mem_Data <= b2.output_Mem_Rd ? mem[b2.output_Mem_Addr] : $urandom;
        b4.input_Mem_Data <= b4.output_Mem_Rd ? mem[b4.output_Mem_Addr] : $urandom;
    end

    logic          cur_rd, cur_stable, cur_busy, cur_done, cur_lk;
    logic          cur_i, cur_j, cur_k;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_w [8];
    assign cur_rd     = sel2 ? b2.output_Mem_Rd   : b4.output_Mem_Rd;
    assign cur_addr   = sel2 ? b2.output_Mem_Addr : b4.output_Mem_Addr;
    assign cur_stable = sel2 ? b2.output_Stable   : b4.output_Stable;
    assign cur_busy   = sel2 ? b2.output_Busy     : b4.output_Busy;
    assign cur_done   = sel2 ? b2.output_Done     : b4.output_Done;
    assign cur_lk     = sel2 ? b2.output_Last_K   : b4.output_Last_K;
    assign cur_i      = sel2 ? b2.output_Tile_I   : b4.output_Tile_I;
    assign cur_j      = sel2 ? b2.output_Tile_J   : b4.output_Tile_J;
    assign cur_k      = sel2 ? b2.output_Tile_K   : b4.output_Tile_K;
    assign cur_w[0]   = sel2 ? b2.output_A11 : b4.output_A11;
    assign cur_w[1]   = sel2 ? b2.output_A12 : b4.output_A12;
    assign cur_w[2]   = sel2 ? b2.output_A21 : b4.output_A21;
    assign cur_w[3]   = sel2 ? b2.output_A22 : b4.output_A22;
    assign cur_w[4]   = sel2 ? b2.output_B11 : b4.output_B11;
    assign cur_w[5]   = sel2 ? b2.output_B12 : b4.output_B12;
    assign cur_w[6]   = sel2 ? b2.output_B21 : b4.output_B21;
    assign cur_w[7]   = sel2 ? b2.output_B22 : b4.output_B22;

    logic [AW-1:0] rd_log [$];
    int            done_cnt = 0;
    always @(negedge clk) begin
        if (cur_rd) rd_log.push_back(cur_addr);
        if (cur_done) done_cnt++;
    end

    tile_t       exp_q [$];
    logic [31:0] obs_d [8][8];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        logic [31:0] orw;
        orw = '0;
        for (int w = 0; w < 8; w++) orw |= cur_w[w];
        chk({tag, "_tiles"}, orw, 0);
        chk({tag, "_ctl"}, {cur_rd, cur_stable, cur_busy, cur_done, cur_lk, cur_i, cur_j, cur_k}, 0);
        chk({tag, "_addr"}, cur_addr, 0);
    endtask

    // Reference: every (i,j,k) in k-innermost order, words straight from the matrix layout.
    task automatic build_model(input int n, input int ab, input int bb);
        tile_t t;
        int    h, r, c, ad;
        h = n / 2;
        exp_q.delete();
        for (int i = 0; i < h; i++)
            for (int j = 0; j < h; j++)
                for (int k = 0; k < h; k++) begin
                    t.i  = 2'(i);
                    t.j  = 2'(j);
                    t.k  = 2'(k);
                    t.lk = (k == h - 1);
                    for (int w = 0; w < 8; w++) begin
                        r = (w / 2) % 2;
                        c = w % 2;
                        if (w < 4) ad = ab + (2 * i + r) * n + 2 * k + c;
                        else       ad = bb + (2 * k + r) * n + 2 * j + c;
                        ad = ad % (1 << AW);
                        t.a[w] = AW'(ad);
                        t.d[w] = mem[ad];
                    end
                    exp_q.push_back(t);
                end
    endtask

    task automatic run_product(input bit use2, input int dmin, input int dmax, input int hmin,
                               input int hmax, input bit poke, input int abort_at);
        tile_t t;
        int    cnt, d, hh, n_t, done0;
        bit    held_ok;
        sel2 = use2;
        #1;
        rd_log.delete();
        done0 = done_cnt;
        n_t = exp_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int tn = 0; tn < n_t; tn++) begin
            t = exp_q[tn];
            cnt = 0;
            while (!cur_stable && cnt < 40) begin
                if (tn == abort_at && cnt == 4) begin
                    #1 rst_n = 1'b0;
                    #1 chk_outputs_zero("async_reset");
                    @(negedge clk);
                    rst_n = 1'b1;
                    repeat (3) @(negedge clk);
                    chk("abort_no_done", done_cnt - done0, 0);
                    return;
                end
                start = (poke && tn == 2 && cnt == 3);
                @(negedge clk);
                cnt++;
            end
            start = 1'b0;
            chk("tile_latency", cnt, (tn == 0) ? 9 : 10);
            chk("stable_high", cur_stable, 1);
            chk("tile_i", cur_i, t.i);
            chk("tile_j", cur_j, t.j);
            chk("tile_k", cur_k, t.k);
            chk("last_k", cur_lk, t.lk);
            chk("read_count", rd_log.size(), 8 * (tn + 1));
            for (int w = 0; w < 8; w++) begin
                if (8 * tn + w < rd_log.size()) chk("rd_addr", rd_log[8 * tn + w], t.a[w]);
                chk("tile_word", cur_w[w], t.d[w]);
                obs_d[tn][w] = cur_w[w];
            end
            d = $urandom_range(dmax, dmin);
            held_ok = 1'b1;
            for (int c = 0; c < d; c++) begin
                start = (poke && tn == 2 && c == 0);
                @(negedge clk);
                if (!cur_stable || cur_rd || cur_i != t.i || cur_j != t.j || cur_k != t.k || cur_lk != t.lk)
                    held_ok = 1'b0;
                for (int w = 0; w < 8; w++) if (cur_w[w] != t.d[w]) held_ok = 1'b0;
            end
            start = 1'b0;
            chk("present_hold", held_ok, 1);
            ack = 1'b1;
            @(negedge clk);
            chk("stable_fall", cur_stable, 0);
            hh = $urandom_range(hmax, hmin);
            held_ok = 1'b1;
            for (int c = 1; c < hh; c++) begin
                @(negedge clk);
                if (cur_rd || cur_stable) held_ok = 1'b0;
            end
            chk("release_hold", held_ok, 1);
            ack = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", cur_done, 1);
        @(negedge clk);
        chk("done_clear", cur_done, 0);
        chk("busy_idle", cur_busy, 0);
        chk("done_count", done_cnt - done0, 1);
        chk("tile_kept", cur_w[7], t.d[7]);
    endtask

    initial begin
        int ab, bb;
        logic [31:0] t101 [8];
        start  = 1'b0;
        ack    = 1'b0;
        sel2   = 1'b0;
        a_base = '0;
        b_base = '0;
        for (int a = 0; a < 1024; a++) mem[a] = $urandom;

        #1 rst_n = 1'b0;
        #2 sel2 = 1'b0;
        #1 chk_outputs_zero("reset_n4");
        chk("reset_state4", st4, ST_IDLE);
        sel2 = 1'b1;
        #1 chk_outputs_zero("reset_n2");
        chk("reset_state2", st2, ST_IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // N=2, float A=[1,2;3,4] at 0, B=[5,6;7,8] at 16
        mem[0]  = 32'h3f80_0000; mem[1]  = 32'h4000_0000;
        mem[2]  = 32'h4040_0000; mem[3]  = 32'h4080_0000;
        mem[16] = 32'h40a0_0000; mem[17] = 32'h40c0_0000;
        mem[18] = 32'h40e0_0000; mem[19] = 32'h4100_0000;
        a_base = 10'd0;
        b_base = 10'd16;
        build_model(2, 0, 16);
        run_product(1'b1, 0, 3, 1, 2, 1'b0, -1);

        // N=2 with A base near the top of the address space
        a_base = 10'd1020;
        b_base = 10'd40;
        build_model(2, 1020, 40);
        run_product(1'b1, 1, 4, 1, 3, 1'b0, -1);

        // N=4 directed content
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem[200 + r * 4 + c] = 32'(r * 4 + c);
                mem[300 + r * 4 + c] = 32'(100 + r * 4 + c);
            end
        a_base = 10'd200;
        b_base = 10'd300;
        build_model(4, 200, 300);
        run_product(1'b0, 0, 2, 1, 2, 1'b0, -1);
        t101 = '{32'd10, 32'd11, 32'd14, 32'd15, 32'd108, 32'd109, 32'd112, 32'd113};
        for (int w = 0; w < 8; w++) chk("tile_101", obs_d[5][w], t101[w]);

        // Slow sink: Ack after 20 cycles, held 5
        run_product(1'b0, 20, 20, 5, 5, 1'b0, -1);

        // Random content and bases, Start poked during FETCH and PRESENT
        for (int a = 0; a < 1024; a++) mem[a] = $urandom;
        ab = $urandom_range(1023, 0);
        bb = $urandom_range(1023, 0);
        a_base = AW'(ab);
        b_base = AW'(bb);
        build_model(4, ab, bb);
        run_product(1'b0, 1, 6, 1, 4, 1'b1, -1);

        // Reset mid-fetch of tile 3, then a fresh product from tile (0,0,0)
        run_product(1'b0, 0, 2, 1, 2, 1'b0, 3);
        run_product(1'b0, 0, 3, 1, 3, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axa_tile_feeder.md
# axa_tile_feeder

Upstream feeder for the `AxA_multiplier` 2x2 block multiplier. It walks an N×N single-precision matrix product A·B stored row-major in a synchronous word RAM. For each block triple (i, j, k) it fetches the 2x2 tiles A[i][k] and B[k][j], then presents them to the multiplier over a four-phase Stable/Ack handshake. Tile indices and a last-k flag travel with each tile so a downstream accumulator can form C[i][j] = Σk A[i][k]·B[k][j].

## Interface
Parameters:
- `N`, default 4: matrix dimension. Must be even and ≥ 2.
- `ADDR_W`, default 10: RAM address width.
- `IDX_W`, default max(1, clog2(N/2)): tile index width.

Ports:
- `input_Clk`, in, 1: the single clock. All state changes on the rising edge.
- `input_Reset`, in, 1: asynchronous, active-low reset.
- `input_Start`, in, 1: begin a product. Sampled only in IDLE.
- `input_A_Base`, in, ADDR_W: address of A(0,0). Latched at start.
- `input_B_Base`, in, ADDR_W: address of B(0,0). Latched at start.
- `output_Mem_Rd`, out, 1: RAM read strobe.
- `output_Mem_Addr`, out, ADDR_W: RAM read address.
- `input_Mem_Data`, in, 32: RAM read data, valid exactly 1 cycle after `output_Mem_Rd`.
- `output_A11`, `output_A12`, `output_A21`, `output_A22`, out, 32 each: A tile.
- `output_B11`, `output_B12`, `output_B21`, `output_B22`, out, 32 each: B tile.
- `output_Stable`, out, 1: tile valid. Drives the multiplier's `input_Stable`.
- `input_AB_Ack`, in, 1: from the multiplier's `output_AB_Ack`.
- `output_Tile_I`, `output_Tile_J`, `output_Tile_K`, out, IDX_W each: indices of the presented tile.
- `output_Last_K`, out, 1: presented tile has k = N/2−1.
- `output_Busy`, out, 1: high in every state except IDLE.
- `output_Done`, out, 1: one-cycle pulse after the final tile is released.

## Operation
- States: IDLE → FETCH → PRESENT → RELEASE, then either FETCH (more tiles) or DONE → IDLE.
- IDLE: `input_Start`=1 latches both bases, clears i, j, k to 0 and the word counter w to 0, and enters FETCH.
  - `input_Start` is ignored in every other state.
- Loop order: k innermost, then j, then i. Total tiles = (N/2)^3.
- FETCH issues one read per cycle, w = 0..7, in this order: A11, A12, A21, A22, B11, B12, B21, B22.
  - A word address = A_Base + (2i+r)·N + (2k+c).
  - B word address = B_Base + (2k+r)·N + (2j+c).
  - r and c are the row and column within the tile, each 0 or 1.
  - Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Each returned word is registered into its tile output one cycle after its read.
  - After the 8th word is captured, enter PRESENT.
- PRESENT: `output_Stable`=1. All tile, index and Last_K outputs are held constant. Remain until `input_AB_Ack`=1 is sampled, then go to RELEASE.
- RELEASE: `output_Stable`=0. Wait until `input_AB_Ack`=0 is sampled, then advance the indices.
  - If the released tile was the last one (i = j = k = N/2−1), go to DONE.
  - Otherwise go to FETCH.
- DONE: `output_Done`=1 for one cycle, then IDLE. Tile outputs keep the last tile's values.
- Reset (asynchronous, active-low): state=IDLE and every output = 0. An in-progress product is abandoned entirely, with no partial Done.

## Timing
- Start sampled at edge T0:
  - `output_Mem_Rd` is high during cycles T0+1 … T0+8.
  - Words are captured at edges T0+2 … T0+9.
  - `output_Stable` rises after edge T0+9. Start-to-Stable latency is 9 cycles.
- Ack high sampled at edge Ta: `output_Stable` falls after Ta.
- Ack low sampled at edge Tb: the next FETCH's first read occurs in cycle Tb+1.
- `output_Mem_Rd` is 0 outside FETCH. `output_Mem_Addr` holds its last value when not reading.
- Ack already high on entry to PRESENT: Stable is still high for at least 1 cycle.
- Ack low on entry to RELEASE: exit RELEASE after 1 cycle.
- Per-tile minimum is 8 fetch cycles + 1 capture cycle + 1 PRESENT cycle + 1 RELEASE cycle = 11 cycles.

## Structure
- Shared package `axa_pkg`:
  - `WORD_W` = 32.
  - State encoding for IDLE, FETCH, PRESENT, RELEASE, DONE.
  - Tile word-order constants (w → A/B, r, c).
- Sub-module `tile_addr_gen`: holds the i/j/k/w counters, computes the address, and flags last-word and last-tile.
- Top level holds the FSM, the capture registers and the handshake.

## Test plan
- N=2, A=[1,2;3,4], B=[5,6;7,8] (floats) at bases 0 and 16:
  - Reads addresses 0, 1, 2, 3, 16, 17, 18, 19.
  - One tile with I=J=K=0 and Last_K=1.
  - Stable high 9 cycles after Start.
  - Done pulse once.
- N=4, A(r,c)=r·4+c, B=100+r·4+c:
  - 8 tiles in (i, j, k) order 000, 001, 010, 011, 100, 101, 110, 111.
  - Tile (1,0,1) has A = {10, 11, 14, 15} and B = {108, 109, 112, 113}.
  - Last_K is set only when k=1.
- Ack delayed 20 cycles and held high 5 cycles: tile outputs stay constant throughout PRESENT; no new read until Ack low is sampled.
- `input_Start` pulsed during FETCH and during PRESENT: no effect; tile sequence and count are unchanged.
- Reset asserted mid-FETCH of tile 3 (N=4):
  - All outputs 0 immediately, with no clock edge needed.
  - After release, a new Start restarts at tile (0,0,0).
- Base 1020 with ADDR_W=10, N=2: A addresses wrap to 1020, 1021, 1022, 1023.
